match_seq_ctrl: RTL and testbench



---
 rtl/match_seq_ctrl.sv | 142 ++++++++++++++
 tb/tb_match_seq_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/match_seq_ctrl.sv
// match_seq_ctrl: sequencing controller for the {b[1], a[3:2]} pattern-status datapath.
// Arms a pattern detector, qualifies a match over a programmable run of
// consecutive valid samples, and holds a sticky status flag that software clears
// with a request/acknowledge handshake.
// Optional feature macro: MATCH_HITCNT_EN adds a saturating hit_total[7:0] output.
module match_seq_ctrl #(
    parameter logic [2:0]  PAT    = 3'b001,
    parameter int          CNT_W  = 4,
    parameter int unsigned THRESH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       a,
    input  logic [3:0]       b,
    input  logic             sample_valid,
    input  logic             en,
    input  logic             cfg_we,
    input  logic [2:0]       cfg_pat,
    input  logic [CNT_W-1:0] cfg_thresh,
    input  logic             clr_req,
    output logic             clr_ack,
    output logic             status,
    output logic [CNT_W-1:0] run_cnt,
    output logic [1:0]       state
`ifdef MATCH_HITCNT_EN
    ,
    output logic [7:0]       hit_total
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        HIT   = 2'd2,
        CLEAR = 2'd3
    } state_t;

    state_t           state_q;
    logic             status_q;
    logic             clr_ack_q;
    logic [CNT_W-1:0] run_cnt_q;
    logic [2:0]       pat_q;
    logic [CNT_W-1:0] thr_q;

    // Combinational helpers; comparisons run one bit wider so the increment cannot wrap.
    logic [2:0]       key_d;
    logic             key_match_d;
    logic [CNT_W:0]   run_inc_d;
    logic [CNT_W:0]   thr_eff_d;
    logic             hit_now_d;
    logic             unused_d;

    assign key_d       = {b[1], a[3:2]};
    assign key_match_d = (key_d == pat_q);
    assign run_inc_d   = {1'b0, run_cnt_q} + (CNT_W+1)'(1);
    // A programmed threshold of zero behaves like one: a single match qualifies.
    assign thr_eff_d   = (thr_q == '0) ? (CNT_W+1)'(1) : {1'b0, thr_q};
    // A qualifying sample only counts while enabled; dropping en takes priority.
    assign hit_now_d   = (state_q == ARMED) && en && sample_valid && key_match_d &&
                         (run_inc_d >= thr_eff_d);
    // Sample bits outside the compare key are deliberately not used.
    assign unused_d    = ^{a[1:0], b[3:2], b[0]};

    // Main controller FSM with registered outputs and configuration registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            status_q  <= 1'b0;
            clr_ack_q <= 1'b0;
            run_cnt_q <= '0;
            pat_q     <= PAT;
            thr_q     <= CNT_W'(THRESH);
        end else begin
            clr_ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    run_cnt_q <= '0;
                    if (cfg_we) begin
                        pat_q <= cfg_pat;
                        thr_q <= cfg_thresh;
                    end
                    if (en) begin
                        state_q <= ARMED;
                    end
                end
                ARMED: begin
                    if (!en) begin
                        state_q   <= IDLE;
                        run_cnt_q <= '0;
                    end else if (sample_valid) begin
                        if (hit_now_d) begin
                            state_q   <= HIT;
                            status_q  <= 1'b1;
                            run_cnt_q <= '0;
                        end else if (key_match_d) begin
                            run_cnt_q <= run_inc_d[CNT_W-1:0];
                        end else begin
                            run_cnt_q <= '0;
                        end
                    end
                end
                HIT: begin
                    status_q <= 1'b1;
                    if (clr_req) begin
                        state_q <= CLEAR;
                    end
                end
                CLEAR: begin
                    // The acknowledge and the status drop appear together on the exit edge.
                    clr_ack_q <= 1'b1;
                    status_q  <= 1'b0;
                    run_cnt_q <= '0;
                    state_q   <= en ? ARMED : IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef MATCH_HITCNT_EN
    logic [7:0] hit_total_q;

    // Saturating count of entries into HIT; only reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_total_q <= 8'd0;
        end else if (hit_now_d && (hit_total_q != 8'hFF)) begin
            hit_total_q <= hit_total_q + 8'd1;
        end
    end

    assign hit_total = hit_total_q;
`endif

    assign state   = state_q;
    assign status  = status_q;
    assign clr_ack = clr_ack_q;
    assign run_cnt = run_cnt_q;

endmodule

// File: tb/tb_match_seq_ctrl.sv
// Testbench for match_seq_ctrl: table of stimulus/expected records driven in
// sequence, expectations queued at drive time and popped after each edge, plus
// hand-written reset and hit-counter sequences.
module tb_match_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] a, b;
    logic       sample_valid, en, cfg_we, clr_req;
    logic [2:0] cfg_pat;
    logic [3:0] cfg_thresh;
    logic       clr_ack, status;
    logic [3:0] run_cnt;
    logic [1:0] state;
`ifdef MATCH_HITCNT_EN
    logic [7:0] hit_total;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    match_seq_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .a           (a),
        .b           (b),
        .sample_valid(sample_valid),
        .en          (en),
        .cfg_we      (cfg_we),
        .cfg_pat     (cfg_pat),
        .cfg_thresh  (cfg_thresh),
        .clr_req     (clr_req),
        .clr_ack     (clr_ack),
        .status      (status),
        .run_cnt     (run_cnt),
        .state       (state)
`ifdef MATCH_HITCNT_EN
        ,
        .hit_total   (hit_total)
`endif
    );

    typedef struct packed {
        logic       en;
        logic       sv;
        logic [2:0] key;
        logic       cw;
        logic [2:0] cp;
        logic [3:0] ct;
        logic       cr;
        logic [1:0] es;
        logic       est;
        logic [3:0] er;
        logic       ea;
    } vec_t;

    localparam int NV = 32;
    vec_t vecs [NV];
    logic [7:0] exp_q [$];

    function automatic vec_t mk(input logic e, input logic s, input logic [2:0] k,
                                input logic w, input logic [2:0] p, input logic [3:0] t,
                                input logic r, input logic [1:0] xs, input logic xst,
                                input logic [3:0] xr, input logic xa);
        vec_t v;
        v.en = e; v.sv = s; v.key = k; v.cw = w; v.cp = p; v.ct = t; v.cr = r;
        v.es = xs; v.est = xst; v.er = xr; v.ea = xa;
        return v;
    endfunction

    task automatic check(input string nm, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got state/status/run_cnt/ack=%b want=%b", nm, got, want);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare after the edge.
    task automatic step(input vec_t v, input string nm);
        logic [7:0] want;
        en           = v.en;
        sample_valid = v.sv;
        a            = {v.key[1:0], 2'($urandom)};
        b            = {2'($urandom), v.key[2], 1'($urandom)};
        cfg_we       = v.cw;
        cfg_pat      = v.cp;
        cfg_thresh   = v.ct;
        clr_req      = v.cr;
        exp_q.push_back({v.es, v.est, v.er, v.ea});
        @(posedge clk);
        #1;
        want = exp_q.pop_front();
        check(nm, {state, status, run_cnt, clr_ack}, want);
        $display("%s: en=%0d sv=%0d key=%b cr=%0d -> state=%0d status=%0d run_cnt=%0d clr_ack=%0d",
                 nm, v.en, v.sv, v.key, v.cr, state, status, run_cnt, clr_ack);
    endtask

    initial begin
        rst = 1'b1;
        en = 0; sample_valid = 0; cfg_we = 0; cfg_pat = 0; cfg_thresh = 0; clr_req = 0;
        a = 0; b = 0;

        //            en sv key  cw cp ct cr   state st run ack
        vecs[0]  = mk(1, 0, 3'd1, 0, 0, 0, 0,  1, 0, 0, 0);
        vecs[1]  = mk(1, 1, 3'd1, 0, 0, 0, 0,  1, 0, 1, 0);
        vecs[2]  = mk(1, 0, 3'd1, 0, 0, 0, 0,  1, 0, 1, 0);  // gap holds run
        vecs[3]  = mk(1, 1, 3'd1, 0, 0, 0, 0,  1, 0, 2, 0);
        vecs[4]  = mk(1, 1, 3'd1, 0, 0, 0, 0,  2, 1, 0, 0);  // third match -> HIT
        vecs[5]  = mk(1, 1, 3'd1, 0, 0, 0, 0,  2, 1, 0, 0);
        vecs[6]  = mk(0, 0, 3'd1, 0, 0, 0, 0,  2, 1, 0, 0);  // en ignored in HIT
        vecs[7]  = mk(1, 0, 3'd0, 0, 0, 0, 1,  3, 1, 0, 0);  // clr_req -> CLEAR
        vecs[8]  = mk(1, 0, 3'd0, 0, 0, 0, 1,  1, 0, 0, 1);  // ack pulse
        vecs[9]  = mk(1, 0, 3'd0, 0, 0, 0, 1,  1, 0, 0, 0);  // no second ack
        vecs[10] = mk(1, 1, 3'd1, 0, 0, 0, 0,  1, 0, 1, 0);
        vecs[11] = mk(1, 1, 3'd1, 0, 0, 0, 0,  1, 0, 2, 0);
        vecs[12] = mk(1, 1, 3'd5, 0, 0, 0, 0,  1, 0, 0, 0);  // mismatch breaks run
        vecs[13] = mk(1, 1, 3'd1, 0, 0, 0, 0,  1, 0, 1, 0);
        vecs[14] = mk(1, 1, 3'd1, 0, 0, 0, 0,  1, 0, 2, 0);
        vecs[15] = mk(1, 1, 3'd3, 0, 0, 0, 0,  1, 0, 0, 0);
        vecs[16] = mk(1, 0, 3'd0, 1, 6, 0, 0,  1, 0, 0, 0);  // cfg in ARMED ignored
        vecs[17] = mk(1, 1, 3'd6, 0, 0, 0, 0,  1, 0, 0, 0);
        vecs[18] = mk(1, 1, 3'd1, 0, 0, 0, 0,  1, 0, 1, 0);
        vecs[19] = mk(1, 1, 3'd1, 0, 0, 0, 0,  1, 0, 2, 0);
        vecs[20] = mk(0, 1, 3'd1, 0, 0, 0, 0,  0, 0, 0, 0);  // en drop beats hit
        vecs[21] = mk(0, 1, 3'd1, 0, 0, 0, 0,  0, 0, 0, 0);  // IDLE ignores samples
        vecs[22] = mk(0, 0, 3'd0, 1, 6, 0, 0,  0, 0, 0, 0);  // cfg pat=110 thr=0
        vecs[23] = mk(1, 0, 3'd0, 0, 0, 0, 0,  1, 0, 0, 0);
        vecs[24] = mk(1, 1, 3'd6, 0, 0, 0, 0,  2, 1, 0, 0);  // thr 0 -> immediate HIT
        vecs[25] = mk(0, 0, 3'd0, 0, 0, 0, 1,  3, 1, 0, 0);
        vecs[26] = mk(0, 0, 3'd0, 0, 0, 0, 0,  0, 0, 0, 1);  // CLEAR -> IDLE with en=0
        vecs[27] = mk(1, 0, 3'd0, 1, 2, 2, 0,  1, 0, 0, 0);  // cfg pat=010 thr=2 and arm
        vecs[28] = mk(1, 1, 3'd2, 0, 0, 0, 0,  1, 0, 1, 0);
        vecs[29] = mk(1, 1, 3'd2, 0, 0, 0, 0,  2, 1, 0, 0);
        vecs[30] = mk(1, 0, 3'd0, 0, 0, 0, 1,  3, 1, 0, 0);
        vecs[31] = mk(1, 0, 3'd0, 0, 0, 0, 0,  1, 0, 0, 1);

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_state", {state, status, run_cnt, clr_ack}, 8'b0);
`ifdef MATCH_HITCNT_EN
        check("reset_hit_total", hit_total, 8'd0);
`endif

        for (int i = 0; i < NV; i++) begin
            step(vecs[i], $sformatf("vec%0d", i));
        end

        // Asynchronous reset while in HIT, then confirm PAT/THRESH defaults are back.
        step(mk(1, 1, 3'd2, 0, 0, 0, 0, 1, 0, 1, 0), "pre_rst_run");
        step(mk(1, 1, 3'd2, 0, 0, 0, 0, 2, 1, 0, 0), "pre_rst_hit");
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_outputs", {state, status, run_cnt, clr_ack}, 8'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(mk(1, 0, 3'd0, 0, 0, 0, 0, 1, 0, 0, 0), "post_rst_arm");
        step(mk(1, 1, 3'd2, 0, 0, 0, 0, 1, 0, 0, 0), "post_rst_old_pat");
        step(mk(1, 1, 3'd1, 0, 0, 0, 0, 1, 0, 1, 0), "post_rst_pat1");
        step(mk(1, 1, 3'd1, 0, 0, 0, 0, 1, 0, 2, 0), "post_rst_pat2");
        step(mk(1, 1, 3'd1, 0, 0, 0, 0, 2, 1, 0, 0), "post_rst_pat3");
        step(mk(0, 0, 3'd0, 0, 0, 0, 1, 3, 1, 0, 0), "post_rst_clr");
        step(mk(0, 0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 1), "post_rst_ack");

`ifdef MATCH_HITCNT_EN
        check("hit_total_one", hit_total, 8'd1);
        step(mk(0, 0, 3'd0, 1, 1, 0, 0, 0, 0, 0, 0), "hc_cfg");
        step(mk(1, 0, 3'd0, 0, 0, 0, 0, 1, 0, 0, 0), "hc_arm");
        for (int n = 0; n < 300; n++) begin
            sample_valid = 1; a = 4'b0100; b = 4'b0000; clr_req = 0;
            @(posedge clk); #1;
            sample_valid = 0; clr_req = 1;
            @(posedge clk); #1;
            clr_req = 0;
            @(posedge clk); #1;
        end
        check("hit_total_sat", hit_total, 8'd255);
        $display("hit_total after 300 extra hits: %0d", hit_total);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
